// File: rtl/divider_array_reconstruct_seq.sv
// Sequential dividend reconstruction checker.
// Rebuilds n_rec = q*d + r from a divider result with a shift-add loop that
// handles one quotient bit per cycle. It then reports |n_ref - n_rec| so that
// approximate divider variants can be scored on-chip.
module divider_array_reconstruct_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   q_in,
    input  logic [DW-1:0]   r_in,
    input  logic [DW-1:0]   d_in,
    input  logic [2*DW-1:0] n_ref,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] n_rec,
    output logic [2*DW-1:0] err_abs,
    output logic            err_flag
);

    localparam int NW = 2 * DW;
    // cnt must be able to hold DW, one past the last MUL index.
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [NW-1:0]   acc;
    logic [NW-1:0]   d_sh;
    logic [NW-1:0]   nref_r;
    logic [DW-1:0]   q_sh;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            cnt_last;
    logic            out_fire;

    // in_ready is a pure decode of the state register, so no input reaches an
    // output combinationally.
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // cnt still holds DW-1 when the final MUL edge arrives.
    assign cnt_last = (cnt == CW'(DW - 1));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so that every flop samples
    // pre-edge values, regardless of the order in which always blocks run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. MUL has a fixed length and no early exit, so the
    // latency does not depend on the data.
    // NOTE: state_next gets a default before the case, so a branch that does
    // not assign it cannot infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = MUL;
            MUL:     if (cnt_last) state_next = CHECK;
            CHECK:   state_next = DONE;
            DONE:    if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands, shift-add multiply, compare, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            d_sh      <= '0;
            q_sh      <= '0;
            nref_r    <= '0;
            cnt       <= '0;
            n_rec     <= '0;
            err_abs   <= '0;
            err_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= {{DW{1'b0}}, r_in};
                        d_sh   <= {{DW{1'b0}}, d_in};
                        q_sh   <= q_in;
                        nref_r <= n_ref;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    // The largest possible sum is (2^DW-1)^2 + (2^DW-1), which
                    // is below 2^(2*DW), so acc cannot wrap.
                    if (q_sh[0]) begin
                        acc <= acc + d_sh;
                    end
                    d_sh <= d_sh << 1;
                    q_sh <= q_sh >> 1;
                    cnt  <= cnt + CW'(1);
                end
                CHECK: begin
                    n_rec     <= acc;
                    err_abs   <= (nref_r >= acc) ? (nref_r - acc) : (acc - nref_r);
                    err_flag  <= (acc != nref_r);
                    out_valid <= 1'b1;
                end
                DONE: begin
                    // The result registers keep their values after the
                    // handshake and are only reloaded by the next CHECK.
                    if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_array_reconstruct_seq.sv
// Self-checking bench for divider_array_reconstruct_seq. A behavioural model
// computes q*d+r and the absolute error with plain integer arithmetic.
module tb_divider_array_reconstruct_seq;

    localparam int DW  = 8;
    localparam int LAT = DW + 1;
    localparam int THR = DW + 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   q_in;
    logic [DW-1:0]   r_in;
    logic [DW-1:0]   d_in;
    logic [2*DW-1:0] n_ref;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] n_rec;
    logic [2*DW-1:0] err_abs;
    logic            err_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    divider_array_reconstruct_seq #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .r_in      (r_in),
        .d_in      (d_in),
        .n_ref     (n_ref),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_rec     (n_rec),
        .err_abs   (err_abs),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference model: dividend reconstruction and error distance.
    function automatic void model(input int q, input int d, input int r, input int n,
                                  output int rec, output int err, output bit flag);
        rec  = q * d + r;
        err  = (n >= rec) ? (n - rec) : (rec - n);
        flag = (err != 0);
    endfunction

    // Present operands and return right after the acceptance edge. The
    // operands are then scrambled to show that they are not reused.
    task automatic start_txn(input int q, input int d, input int r, input int n,
                             output int acc_cyc);
        @(negedge clk);
        q_in     = DW'(q);
        d_in     = DW'(d);
        r_in     = DW'(r);
        n_ref    = (2*DW)'(n);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        q_in     = DW'($urandom);
        d_in     = DW'($urandom);
        r_in     = DW'($urandom);
        n_ref    = (2*DW)'($urandom);
    endtask

    // Count edges until out_valid appears. The wait is bounded.
    task automatic wait_valid(output int lat, output bit timed_out);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        timed_out = (out_valid !== 1'b1);
    endtask

    // Run one full transaction with an optional out_ready stall.
    task automatic drive_txn(input int q, input int d, input int r, input int n,
                             input int stall, output int acc_cyc, output int lat,
                             output int rec, output int err, output bit flag,
                             output bit timed_out, output bit hs_ok);
        out_ready = (stall == 0);
        start_txn(q, d, r, n, acc_cyc);
        wait_valid(lat, timed_out);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        rec  = int'(n_rec);
        err  = int'(err_abs);
        flag = err_flag;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        hs_ok = (out_valid === 1'b0) && (in_ready === 1'b1);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q_in      = '0;
        d_in      = '0;
        r_in      = '0;
        n_ref     = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || n_rec !== '0 ||
            err_abs !== '0 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b n_rec=%0d err_abs=%0d err_flag=%b, want 1 0 0 0 0",
                     in_ready, out_valid, n_rec, err_abs, err_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int q;
        int d;
        int r;
        int n;
    } vec_t;

    task automatic test_directed;
        vec_t v[6];
        int acc_cyc, lat, rec, err, erec, eerr;
        bit flag, eflag, to, hs;
        v[0] = '{5, 3, 2, 17};
        v[1] = '{255, 255, 255, 65280};
        v[2] = '{33, 3, 0, 100};
        v[3] = '{34, 3, 0, 100};
        v[4] = '{200, 0, 13, 13};
        v[5] = '{0, 77, 76, 500};
        foreach (v[i]) begin
            drive_txn(v[i].q, v[i].d, v[i].r, v[i].n, 0, acc_cyc, lat, rec, err, flag, to, hs);
            model(v[i].q, v[i].d, v[i].r, v[i].n, erec, eerr, eflag);
            checks++;
            if (to || lat != LAT) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d timeout=%0d, want %0d", i, lat, to, LAT);
            end
            checks++;
            if (rec != erec) begin
                errors++;
                $display("FAIL directed[%0d] n_rec: got %0d, want %0d", i, rec, erec);
            end
            checks++;
            if (err != eerr || flag != eflag) begin
                errors++;
                $display("FAIL directed[%0d] err_abs/flag: got %0d/%0d, want %0d/%0d",
                         i, err, flag, eerr, eflag);
            end
            checks++;
            if (!hs) begin
                errors++;
                $display("FAIL directed[%0d] handshake: out_valid=%b in_ready=%b, want 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random;
        int q, d, r, n, acc_cyc, lat, rec, err, erec, eerr, stall;
        bit flag, eflag, to, hs;
        for (int i = 0; i < 40; i++) begin
            q = int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 255));
            r = int'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0:       n = q * d + r;
                1:       n = (q * d + r + int'($urandom_range(0, 6)) - 3) & 16'hFFFF;
                default: n = int'($urandom_range(0, 65535));
            endcase
            stall = int'($urandom_range(0, 3));
            drive_txn(q, d, r, n, stall, acc_cyc, lat, rec, err, flag, to, hs);
            model(q, d, r, n, erec, eerr, eflag);
            checks++;
            if (to || lat != LAT || rec != erec || err != eerr || flag != eflag || !hs) begin
                errors++;
                $display("FAIL random[%0d] q=%0d d=%0d r=%0d n=%0d: lat=%0d rec=%0d err=%0d flag=%0d hs=%0d, want lat=%0d rec=%0d err=%0d flag=%0d hs=1",
                         i, q, d, r, n, lat, rec, err, flag, hs, LAT, erec, eerr, eflag);
            end
        end
    endtask

    task automatic test_back_to_back;
        int q, d, r, n, acc_cyc, prev_cyc, lat, rec, err, erec, eerr;
        bit flag, eflag, to, hs;
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            q = int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 255));
            r = int'($urandom_range(0, 255));
            n = q * d + r;
            drive_txn(q, d, r, n, 0, acc_cyc, lat, rec, err, flag, to, hs);
            model(q, d, r, n, erec, eerr, eflag);
            checks++;
            if (to || rec != erec || err != eerr || flag != eflag) begin
                errors++;
                $display("FAIL b2b[%0d] result: rec=%0d err=%0d flag=%0d, want %0d %0d %0d",
                         i, rec, err, flag, erec, eerr, eflag);
            end
            if (i > 0) begin
                checks++;
                if (acc_cyc - prev_cyc != THR) begin
                    errors++;
                    $display("FAIL b2b[%0d] throughput: got %0d cycles, want %0d",
                             i, acc_cyc - prev_cyc, THR);
                end
            end
            prev_cyc = acc_cyc;
        end
    endtask

    task automatic test_backpressure;
        int acc_cyc, lat, erec, eerr, spurious;
        bit eflag, to;
        model(123, 45, 6, 5541, erec, eerr, eflag);
        out_ready = 1'b0;
        start_txn(123, 45, 6, 5541, acc_cyc);
        wait_valid(lat, to);
        checks++;
        if (to || lat != LAT) begin
            errors++;
            $display("FAIL bp latency: got %0d timeout=%0d, want %0d", lat, to, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            q_in     = DW'($urandom);
            d_in     = DW'($urandom);
            r_in     = DW'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(n_rec) != erec ||
                int'(err_abs) != eerr || err_flag !== eflag) begin
                errors++;
                $display("FAIL bp hold[%0d]: out_valid=%b in_ready=%b n_rec=%0d err_abs=%0d flag=%b, want 1 0 %0d %0d %0d",
                         i, out_valid, in_ready, n_rec, err_abs, err_flag, erec, eerr, eflag);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || int'(n_rec) != erec) begin
            errors++;
            $display("FAIL bp release: out_valid=%b in_ready=%b n_rec=%0d, want 0 1 %0d",
                     out_valid, in_ready, n_rec, erec);
        end
        spurious = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL bp no_accept: %0d busy/valid cycles after release, want 0", spurious);
        end
    endtask

    task automatic test_reset_mid;
        int acc_cyc, lat, rec, err, erec, eerr, spurious;
        bit flag, eflag, to, hs;
        out_ready = 1'b1;
        start_txn(200, 150, 9, 30009, acc_cyc);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || n_rec !== '0 || err_abs !== '0 || err_flag !== 1'b0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: out_valid=%b n_rec=%0d err_abs=%0d flag=%b in_ready=%b, want 0 0 0 0 1",
                     out_valid, n_rec, err_abs, err_flag, in_ready);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        spurious = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL rst_mid discard: out_valid seen %0d cycles, want 0", spurious);
        end
        drive_txn(7, 9, 4, 67, 0, acc_cyc, lat, rec, err, flag, to, hs);
        model(7, 9, 4, 67, erec, eerr, eflag);
        checks++;
        if (to || lat != LAT || rec != erec || err != eerr || flag != eflag || !hs) begin
            errors++;
            $display("FAIL rst_mid fresh: lat=%0d rec=%0d err=%0d flag=%0d hs=%0d, want %0d %0d %0d %0d 1",
                     lat, rec, err, flag, hs, LAT, erec, eerr, eflag);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
